// File: rtl/packet_link_serializer.sv
// packet_link_serializer: round-robin arbiter plus message buffer that streams
// one whole multi-word message at a time onto a single valid/ready link.
// Each packet carries first/last flags and the source channel; messages from
// different channels never interleave.

module packet_link_serializer #(
  parameter  int PKT_WIDTH = 32,
  parameter  int N_CH      = 2,
  parameter  int MAX_WORDS = 4,
  localparam int CNT_W     = $clog2(MAX_WORDS + 1),
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N_CH-1:0]                       in_valid,
  output logic [N_CH-1:0]                       in_ready,
  input  logic [N_CH*MAX_WORDS*PKT_WIDTH-1:0]   in_words,
  input  logic [N_CH*CNT_W-1:0]                 in_count,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [PKT_WIDTH-1:0]                  out_pkt,
  output logic                                  out_first,
  output logic                                  out_last,
  output logic [CH_W-1:0]                       out_ch,
  output logic                                  busy,
  output logic                                  count_err
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     idx_q, idx_d;        // index of the word on the link
  logic [CNT_W-1:0]     last_idx_q, last_idx_d;
  logic [CH_W-1:0]      ptr_q, ptr_d;        // round-robin start point
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [PKT_WIDTH-1:0] pkt_q, pkt_d;
  logic                 first_q, first_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;

  logic [PKT_WIDTH-1:0] buf_q [MAX_WORDS];
  logic [PKT_WIDTH-1:0] buf_d [MAX_WORDS];   // words of the granted channel

  logic                 grant_valid;
  logic [CH_W-1:0]      grant;
  logic [CNT_W-1:0]     raw_count;
  logic [CNT_W-1:0]     n_m1;                // clamped word count minus one
  logic                 count_bad;
  logic [CNT_W-1:0]     nxt_idx;
  logic [PKT_WIDTH-1:0] nxt_word;
  logic                 out_fire;
  logic                 free;
  logic                 accept;

  // Round-robin search for the first requesting channel starting at ptr.
  always_comb begin
    int c;
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    grant_valid = 1'b0;
    grant       = '0;
    c           = 0;
    for (int i = 0; i < N_CH; i++) begin
      c = (int'(ptr_q) + i) % N_CH;
      if (!grant_valid && in_valid[c]) begin
        grant_valid = 1'b1;
        grant       = CH_W'(c);
      end
    end
  end

  // Route the granted channel's words and count out of the flat input buses.
  always_comb begin
    raw_count = '0;
    for (int k = 0; k < MAX_WORDS; k++) buf_d[k] = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (CH_W'(c) == grant) begin
        raw_count = in_count[c*CNT_W +: CNT_W];
        for (int k = 0; k < MAX_WORDS; k++)
          buf_d[k] = in_words[(c*MAX_WORDS + k)*PKT_WIDTH +: PKT_WIDTH];
      end
    end
  end

  // Clamp the requested count into 1..MAX_WORDS and flag out-of-range values.
  always_comb begin
    n_m1      = raw_count - CNT_W'(1);
    count_bad = 1'b0;
    if (raw_count == '0) begin
      n_m1      = '0;
      count_bad = 1'b1;
    end else if (int'(raw_count) > MAX_WORDS) begin
      n_m1      = CNT_W'(MAX_WORDS - 1);
      count_bad = 1'b1;
    end
  end

  // Fetch the word that follows the one currently on the link.
  always_comb begin
    nxt_idx  = idx_q + CNT_W'(1);
    nxt_word = '0;
    for (int k = 0; k < MAX_WORDS; k++)
      if (CNT_W'(k) == nxt_idx) nxt_word = buf_q[k];
  end

  assign out_fire = (state_q == SEND) && out_ready;
  assign free     = (state_q == IDLE) || (out_fire && last_q);
  assign accept   = free && grant_valid && !reset;
  assign in_ready = accept ? (N_CH'(1) << grant) : '0;

  // Next-state and registered-output computation for the serializer FSM.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    ptr_d      = ptr_q;
    ch_d       = ch_q;
    pkt_d      = pkt_q;
    first_d    = first_q;
    last_d     = last_q;
    err_d      = 1'b0;
    if (accept) begin
      state_d    = SEND;
      idx_d      = '0;
      last_idx_d = n_m1;
      ptr_d      = (grant == CH_W'(N_CH - 1)) ? '0 : grant + CH_W'(1);
      ch_d       = grant;
      pkt_d      = buf_d[0];
      first_d    = 1'b1;
      last_d     = (n_m1 == '0);
      err_d      = count_bad;
    end else if (out_fire) begin
      if (last_q) begin
        state_d = IDLE;
        first_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        idx_d   = nxt_idx;
        pkt_d   = nxt_word;
        first_d = 1'b0;
        last_d  = (nxt_idx == last_idx_q);
      end
    end
  end

  // FSM state and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_idx_q <= '0;
      ptr_q      <= '0;
      ch_q       <= '0;
      pkt_q      <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      ptr_q      <= ptr_d;
      ch_q       <= ch_d;
      pkt_q      <= pkt_d;
      first_q    <= first_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  // Capture all words of the granted message on acceptance.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; its contents are only read while in
    // SEND, which is reachable solely through a fresh capture.
    if (accept)
      for (int k = 0; k < MAX_WORDS; k++) buf_q[k] <= buf_d[k];
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_pkt   = pkt_q;
  assign out_first = first_q;
  assign out_last  = last_q;
  assign out_ch    = ch_q;
  assign count_err = err_q;

endmodule

// File: doc/packet_link_serializer.md
# packet_link_serializer

Parametrised multi-channel packet serializer between the front end (instruction decoder, register renaming unit) and the re-order buffer. Each source channel presents a whole multi-word message at once, for example a 4-word decoder-to-ROB message or a 2-word RRU-to-ROB message. The block round-robin arbitrates between channels and streams the granted message one packet per cycle onto a single valid/ready link. It tags each packet with first/last flags and the source channel, and never interleaves messages.

## Interface
Parameters:
- PKT_WIDTH, 32: packet (word) width in bits.
- N_CH, 2: number of source channels (≥1).
- MAX_WORDS, 4: maximum words per message (≥1).
- Derived localparams:
  - CNT_W = $clog2(MAX_WORDS+1).
  - CH_W = max(1, $clog2(N_CH)).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  N_CH  channel c has a message pending.
- in_ready  out  N_CH  message of channel c accepted this cycle; one-hot or zero.
- in_words  in  N_CH*MAX_WORDS*PKT_WIDTH  word k of channel c at [(c*MAX_WORDS+k)*PKT_WIDTH +: PKT_WIDTH]; word 0 is sent first.
- in_count  in  N_CH*CNT_W  word count of channel c at [c*CNT_W +: CNT_W].
- out_valid  out  1  out_pkt is valid.
- out_ready  in  1  downstream accepts the packet.
- out_pkt  out  PKT_WIDTH  current packet.
- out_first  out  1  out_pkt is word 0 of its message.
- out_last  out  1  out_pkt is the final word of its message.
- out_ch  out  CH_W  source channel of the current message.
- busy  out  1  a message is held in the buffer.
- count_err  out  1  one-cycle pulse: the accepted message had an out-of-range count.

## Operation
- Two states:
  - IDLE: buffer empty.
  - SEND: buffer holds a message; word index idx runs from 0 to n-1.
- Free condition: state IDLE, or state SEND with out_valid && out_ready && out_last.
- Arbitration:
  - Round-robin pointer ptr, reset to 0.
  - Grant g is the first c with in_valid[c], searching c = ptr, ptr+1, … mod N_CH.
  - in_ready[g] = free condition && any in_valid. in_ready may depend combinationally on in_valid.
  - On acceptance: ptr ← (g+1) mod N_CH; all MAX_WORDS words of channel g are captured; n is stored; out_ch ← g; idx ← 0; state ← SEND.
- Count rules:
  - in_count = 0 is treated as n = 1.
  - in_count > MAX_WORDS is treated as n = MAX_WORDS.
  - Either case pulses count_err in the cycle after acceptance.
  - Unused words are ignored.
- Output generation:
  - out_pkt = buffer[idx].
  - out_first = (idx == 0).
  - out_last = (idx == n-1).
  - out_valid = (state == SEND).
- Handshake:
  - On out_valid && out_ready with !out_last: idx increments.
  - On out_last handshake: state goes to IDLE, unless a new message is accepted in the same cycle, in which case it stays in SEND with idx = 0.
- While out_valid && !out_ready, out_pkt, out_first, out_last and out_ch hold stable.
- busy = (state == SEND).

## Timing
- Reset values: out_valid 0, out_pkt 0, out_first 0, out_last 0, out_ch 0, busy 0, count_err 0, ptr 0, state IDLE. in_ready is forced to 0 while reset is high.
- Latency: a message accepted at rising edge T has word 0 on the output from T+1.
- Throughput: with out_ready held high, an n-word message occupies exactly n cycles. Consecutive messages stream with no bubble, including n = 1 messages every cycle.
- Simultaneous requests are served strictly in round-robin order. A channel waits at most N_CH-1 messages.
- A source must hold in_valid, in_words and in_count stable until in_ready. Changes before acceptance are simply resampled.
- Reset mid-message: outputs clear asynchronously, the in-flight message is dropped, and no residual words appear after release.

## Test plan
- Single message: ch0 sends count=4, words 0xA0..0xA3, out_ready=1.
  - in_ready[0] pulses in cycle 0.
  - 0xA0..0xA3 appear in cycles 1–4.
  - out_first only on 0xA0, out_last only on 0xA3, out_ch=0, busy falls after cycle 4.
- Arbitration: both channels hold in_valid continuously after reset, with 2-word messages.
  - Grants go 0,1,0,1.
  - out_ch changes every 2 cycles with no idle cycle between messages.
- Backpressure: drop out_ready for 3 cycles while word 1 of a 4-word message is presented.
  - out_pkt, out_first, out_last and out_ch stay frozen.
  - No in_ready is asserted.
  - The message resumes and completes intact.
- Count clamping, with MAX_WORDS=4:
  - in_count=0 yields 1 word with first=last=1 and count_err pulses once.
  - in_count=7 yields 4 words and count_err pulses once.
  - in_count=3 yields no count_err.
- Reset mid-operation: assert reset during word 2 of 4.
  - out_valid drops before the next clock edge.
  - After release, ptr=0, busy=0, and no word 3 is emitted.
- Back-to-back single-word messages: ch1 sends count=1 every cycle with out_ready=1.
  - One packet per cycle.
  - out_first=out_last=1 on each packet.
  - in_ready[1] is high every cycle.
